ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable).
- Opposite direction to the keyboard receive path. It shares the same PS2_CLK/PS2_DAT pins through open-drain enables at the top level.
- The device generates the clock. This block inhibits the bus, issues a request-to-send, shifts data out on device falling edges, then checks the device ACK.

Parameters:
- INHIBIT_CYCLES, 6000, clock cycles the host holds PS2_CLK low before request-to-send (120 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000, watchdog limit in cycles between consecutive device falling edges (15 ms at 50 MHz).

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- send  in  1  start strobe; sampled only in IDLE
- tx_byte  in  8  byte to send; latched when send is accepted
- busy  out  1  high from the cycle after acceptance until the cycle done/error pulses
- done  out  1  one-cycle pulse: byte sent and ACK received
- error  out  1  one-cycle pulse: timeout or missing ACK
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous)
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release (pin floats high)
- ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release

Behaviour:
- Reset values: busy=0, done=0, error=0, ps2_clk_oe=0, ps2_dat_oe=0; state IDLE; counters 0. Reset asserted mid-transfer releases both lines immediately (asynchronous), with no done/error pulse.
- Input synchronisation:
  - ps2_clk_in and ps2_dat_in each pass through 2 flops.
  - A third clk flop holds the previous value.
  - fall = prev & ~sync. Edge detection therefore lags the pin by 2–3 cycles.
- States and transitions:
  - IDLE: lines released. On send=1, latch tx_byte, compute parity = ~^tx_byte (odd parity), go to INHIBIT. The next cycle has busy=1 and ps2_clk_oe=1.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then ps2_dat_oe=1 for one cycle with the clock still held (REQ).
  - REQ: next cycle ps2_clk_oe=0, ps2_dat_oe stays 1 (start bit = 0); clear watchdog; go to SHIFT with bit index 0.
  - SHIFT, on each fall:
    - Falls 1–8: ps2_dat_oe = ~tx_byte[idx], LSB first.
    - Fall 9: ps2_dat_oe = ~parity.
    - Fall 10: ps2_dat_oe=0 (stop bit = 1).
  - ACK: on fall 11, sample synced data. 0 = ACK → go to RELEASE; 1 = NACK → error pulse, go to IDLE.
  - RELEASE: wait until synced clk=1 and synced dat=1, then pulse done, deassert busy, go to IDLE.
- Edge timing: line changes take effect the cycle after fall is detected. No action is taken on rising edges.
- Watchdog:
  - Counts in SHIFT, ACK and RELEASE; cleared on every fall.
  - Reaching TIMEOUT_CYCLES → both oe=0, error pulse, busy=0, IDLE.
- done and error are mutually exclusive, each lasting exactly 1 cycle. busy falls in the same cycle as the pulse.
- send while busy=1 is ignored; the latched byte does not change. send asserted in the same cycle done pulses is ignored; a new send is accepted from the next IDLE cycle.
- The design never drives a line high: only the oe outputs are generated, and the top level ties each pin as oe ? 0 : Z.

Test Plan:
- Bench uses INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=2000; the device model toggles clk at a 40-cycle period and ACKs.
- Send 0xED:
  - Required bus sequence: ps2_clk_oe high exactly 20 cycles; dat low before clk release.
  - Device samples 0, then 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - ACK → done pulse, busy low.
- Send 0x01 → data bits 1,0,0,0,0,0,0,0, parity 0. Send 0xFF → parity 1. All complete with done.
- Device does not ACK (dat high on edge 11) → error=1 for 1 cycle, done never asserted, both oe=0.
- Device never clocks after REQ → error exactly 2000 cycles after clk release (± sync latency ≤3), lines released.
- Reset pulse during bit 4 → in the same cycle ps2_clk_oe=0, ps2_dat_oe=0, busy=0. A following send 0xF4 completes normally.
- send re-asserted every cycle during a 0xED transfer → only 0xED bits appear; exactly one done pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (open-drain enables only)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          parity_q, parity_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        parity_d = parity_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                // The cycle carrying a done/error pulse is already IDLE but must not accept.
                if (send && !done_q && !error_q) begin
                    byte_d   = tx_byte;
                    parity_d = ~^tx_byte;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT, S_ACK, S_RELEASE: begin
                cnt_d = fall ? '0 : cnt_q + 1'b1;
                if (!fall && cnt_q == WD_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    busy_d   = 1'b0;
                    error_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else if (state_q == S_SHIFT) begin
                    if (fall) begin
                        if (idx_q < 4'd8) begin
                            dat_oe_d = ~byte_q[idx_q[2:0]];
                        end else if (idx_q == 4'd8) begin
                            dat_oe_d = ~parity_q;
                        end else begin
                            dat_oe_d = 1'b0;
                            state_d  = S_ACK;
                        end
                        idx_d = idx_q + 4'd1;
                    end
                end else if (state_q == S_ACK) begin
                    if (fall) begin
                        if (!dat_s2_q) begin
                            state_d = S_RELEASE;
                        end else begin
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end
                end else if (clk_s2_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            // Idle bus level, so leaving reset never fakes a falling edge.
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            parity_q   <= parity_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed vector bench for ps2_host_tx with a clocking/ACKing device model
module tb_ps2_host_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] tx_byte;
    logic       busy, done, error;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_rel = 1'b1;
    logic       dev_dat_low = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    always #5 clock = ~clock;

    // Open-drain wired-AND of host enables and device drive, pulled up when released.
    assign ps2_clk_in = dev_clk_rel & ~ps2_clk_oe;
    assign ps2_dat_in = ~dev_dat_low & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
        .clock      (clock),
        .reset      (reset),
        .send       (send),
        .tx_byte    (tx_byte),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic        spam;
        logic [10:0] frame;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic dev_transfer(input logic ack, output logic [10:0] bits);
        bits = '0;
        repeat (10) @(negedge clock);
        bits[0] = ps2_dat_in;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_rel = 1'b0;
            repeat (20) @(negedge clock);
            dev_clk_rel = 1'b1;
            if (k <= 10) bits[k] = ps2_dat_in;
            if (k == 10) dev_dat_low = ack;
            if (k == 11) dev_dat_low = 1'b0;
            else repeat (20) @(negedge clock);
        end
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int n, inh, req, d0, e0;
        logic [10:0] fr;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clock);
        tx_byte = v.data;
        send    = 1'b1;
        @(negedge clock);
        if (v.spam) tx_byte = 8'h00;
        else send = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        inh = 0; req = 0; n = 0;
        while (ps2_clk_oe && n < 200) begin
            if (ps2_dat_oe) req++;
            else inh++;
            n++;
            @(negedge clock);
        end
        check({tag, "_inhibit_cycles"}, inh, 20);
        check({tag, "_req_cycles"}, req, 1);
        check({tag, "_start_bit_held"}, ps2_dat_oe, 1);
        dev_transfer(v.ack, fr);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_busy_drop_in_time"}, (n < 200), 1);
        @(negedge clock);
        send = 1'b0;
        repeat (3) @(negedge clock);
        check({tag, "_frame"}, fr, v.frame);
        check({tag, "_done_pulses"}, done_cnt - d0, v.exp_done);
        check({tag, "_error_pulses"}, err_cnt - e0, v.exp_err);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_clk_oe_end"}, ps2_clk_oe, 0);
        check({tag, "_dat_oe_end"}, ps2_dat_oe, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n, d0, e0;
        vec_t f4;
        // frame bit 0 = start, 1..8 = data LSB first, 9 = odd parity, 10 = stop
        vecs[0] = '{8'hED, 1'b1, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 1, 0};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, {1'b1, 1'b1, 8'hA5, 1'b0}, 0, 1};
        vecs[4] = '{8'hED, 1'b1, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1, 0};
        f4      = '{8'hF4, 1'b1, 1'b0, {1'b1, 1'b0, 8'hF4, 1'b0}, 1, 0};

        reset = 1'b1; send = 1'b0; tx_byte = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 5; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Device never clocks: watchdog fires ~2000 cycles after clock release.
        e0 = err_cnt;
        @(negedge clock);
        tx_byte = 8'h55; send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        n = 0;
        while (ps2_clk_oe && n < 200) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (!error && n < 2100) begin
            @(negedge clock);
            n++;
        end
        total_cnt++;
        if (n >= 1997 && n <= 2003) pass_cnt++;
        else $display("FAIL timeout_latency actual=%0d expected=2000(+-3)", n);
        check("timeout_clk_oe", ps2_clk_oe, 0);
        check("timeout_dat_oe", ps2_dat_oe, 0);
        check("timeout_busy", busy, 0);
        @(negedge clock);
        check("timeout_error_one_cycle", error, 0);
        check("timeout_error_pulses", err_cnt - e0, 1);

        // Asynchronous reset in the middle of the data bits.
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clock);
        tx_byte = 8'h3C; send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        n = 0;
        while (ps2_clk_oe && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (10) @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            dev_clk_rel = 1'b0;
            repeat (20) @(negedge clock);
            dev_clk_rel = 1'b1;
            repeat (20) @(negedge clock);
        end
        dev_clk_rel = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_dat_oe", ps2_dat_oe, 0);
        check("midrst_busy", busy, 0);
        dev_clk_rel = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_error", err_cnt - e0, 0);
        run_vector(f4, "after_rst_f4");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
